// File: rtl/alu_tv_writer_pkg.sv
// Shared types for the ALU test-vector writer: ALU opcodes, the captured
// record layout, serializer states and a reference ALU model.
package alu_pkg;

    // ALU function codes; 3'b011 is reserved and evaluates to zero.
    typedef enum logic [2:0] {
        AND  = 3'b000,
        OR   = 3'b001,
        ADD  = 3'b010,
        ANDN = 3'b100,
        ORN  = 3'b101,
        SUB  = 3'b110,
        SLT  = 3'b111
    } alu_op_t;

    // Words emitted per record: f, a, b, y, zero.
    localparam int WORDS_PER_RECORD = 5;

    // One captured ALU transaction (3 + 32 + 32 + 32 + 1 = 100 bits).
    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        zero;
    } tv_rec_t;

    // Serializer position within the current record.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        W_F  = 3'd1,
        W_A  = 3'd2,
        W_B  = 3'd3,
        W_Y  = 3'd4,
        W_Z  = 3'd5
    } ser_state_t;

    // Reference 32-bit ALU; SLT is a signed compare.
    function automatic logic [31:0] alu_model(input logic [2:0] f,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        case (f)
            AND:     r = a & b;
            OR:      r = a | b;
            ADD:     r = a + b;
            ANDN:    r = a & ~b;
            ORN:     r = a | ~b;
            SUB:     r = a - b;
            SLT:     r = {31'b0, ($signed(a) < $signed(b))};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_tv_writer_if.sv
// Capture and word-stream bundle for alu_tv_writer.
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid && ready; valid never waits on ready, and while valid && !ready
// the payload holds steady until the transfer happens.
interface alu_tv_writer_if;

    logic        cap_valid;
    logic        cap_ready;
    logic [2:0]  cap_f;
    logic [31:0] cap_a;
    logic [31:0] cap_b;
    logic [31:0] cap_y;
    logic        cap_zero;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    // Environment side: drives captures, drains words.
    modport master (
        output cap_valid, cap_f, cap_a, cap_b, cap_y, cap_zero,
        input  cap_ready,
        input  out_valid, out_data, out_last,
        output out_ready
    );

    // Writer side: accepts captures, produces words.
    modport slave (
        input  cap_valid, cap_f, cap_a, cap_b, cap_y, cap_zero,
        output cap_ready,
        output out_valid, out_data, out_last,
        input  out_ready
    );

endinterface

// File: rtl/alu_tv_writer_fifo.sv
// Record FIFO for alu_tv_writer. Pointers carry one extra wrap bit so
// full and empty are distinguishable; push is ignored when full and pop
// is ignored when empty.
module alu_tv_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  tv_rec_t                wr_data,
    input  logic                   pop,
    output tv_rec_t                rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    tv_rec_t       mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Advance pointers; they wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/alu_tv_writer.sv
// ALU transaction recorder: captures {f,a,b,y,zero} records into a FIFO and
// serializes each as five 32-bit words (f, a, b, y, zero) on a stream.
// Optional macro ALU_TV_CHECK_EN adds a sticky err output that flags
// captures whose y/zero disagree with the reference ALU model.
module alu_tv_writer
    import alu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int MAX_RECORDS = 21
) (
    input  logic                               clk,
    input  logic                               rst_n,
    alu_tv_writer_if.slave                     bus,
    output logic [$clog2(MAX_RECORDS+1)-1:0]   rec_count,
    output logic                               done,
    output ser_state_t                         fsm_state
`ifdef ALU_TV_CHECK_EN
    ,
    output logic                               err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_RECORDS+1);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    ser_state_t  state;
    ser_state_t  state_d;
    tv_rec_t     wr_rec;
    tv_rec_t     head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    logic        fifo_pop;
    logic        cap_fire;
    logic        cap_ready_c;
    logic        stop_pending;
    logic [31:0] committed;
    logic        out_valid_c;
    logic        out_last_c;
    logic [31:0] out_data_c;
    logic        out_fire;

    // Records stored plus records emitted may never exceed the limit, so
    // capture closes as soon as the last permitted record is queued.
    assign committed    = 32'(fifo_count) + 32'(rec_count);
    assign stop_pending = (committed == 32'(MAX_RECORDS));
    assign cap_ready_c  = !fifo_full && !done && !stop_pending;
    assign cap_fire     = bus.cap_valid && cap_ready_c;

    assign wr_rec = '{f: bus.cap_f, a: bus.cap_a, b: bus.cap_b,
                      y: bus.cap_y, zero: bus.cap_zero};

    alu_tv_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cap_fire),
        .wr_data (wr_rec),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_fire = out_valid_c && bus.out_ready;

    // Serializer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Serializer next state: one word per handshake, chain records back to back.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (!fifo_empty) state_d = W_F;
            W_F:  if (out_fire)    state_d = W_A;
            W_A:  if (out_fire)    state_d = W_B;
            W_B:  if (out_fire)    state_d = W_Y;
            W_Y:  if (out_fire)    state_d = W_Z;
            W_Z:  if (out_fire)    state_d = ((fifo_count > CNT_ONE) || cap_fire) ? W_F : IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Serializer outputs: word select from the FIFO head, pop on the last word.
    always_comb begin
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        out_data_c  = 32'd0;
        fifo_pop    = 1'b0;
        case (state)
            W_F: begin
                out_valid_c = 1'b1;
                out_data_c  = {29'b0, head.f};
            end
            W_A: begin
                out_valid_c = 1'b1;
                out_data_c  = head.a;
            end
            W_B: begin
                out_valid_c = 1'b1;
                out_data_c  = head.b;
            end
            W_Y: begin
                out_valid_c = 1'b1;
                out_data_c  = head.y;
            end
            W_Z: begin
                out_valid_c = 1'b1;
                out_last_c  = 1'b1;
                out_data_c  = {31'b0, head.zero};
                fifo_pop    = bus.out_ready;
            end
            default: begin
                out_valid_c = 1'b0;
            end
        endcase
    end

    // Emitted-record counter and sticky completion flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_count <= '0;
            done      <= 1'b0;
        end else if (fifo_pop) begin
            rec_count <= rec_count + CW'(1);
            if (rec_count == CW'(MAX_RECORDS-1)) done <= 1'b1;
        end
    end

`ifdef ALU_TV_CHECK_EN
    logic [31:0] model_y;
    logic        model_zero;
    logic        cap_mismatch;

    assign model_y      = alu_model(bus.cap_f, bus.cap_a, bus.cap_b);
    assign model_zero   = (model_y == 32'd0);
    assign cap_mismatch = (model_y != bus.cap_y) || (model_zero != bus.cap_zero);

    // Sticky flag for any accepted capture the reference model disagrees with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        err <= 1'b0;
        else if (cap_fire && cap_mismatch) err <= 1'b1;
    end
`endif

    assign bus.cap_ready = cap_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;
    assign bus.out_last  = out_last_c;
    assign fsm_state     = state;

endmodule

// File: tb/tb_alu_tv_writer.sv
// Directed bench for alu_tv_writer: the driver pushes the five expected
// words of every accepted capture into exp_q; the monitor pops and compares
// on each presented word.
module tb_alu_tv_writer;
    import alu_pkg::*;

    localparam int DEPTH       = 4;
    localparam int MAX_RECORDS = 21;
    localparam int CW          = $clog2(MAX_RECORDS+1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] rec_count;
    logic          done;
    ser_state_t    fsm_state;
`ifdef ALU_TV_CHECK_EN
    logic          err;
`endif

    alu_tv_writer_if bus();

    alu_tv_writer #(.DEPTH(DEPTH), .MAX_RECORDS(MAX_RECORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .rec_count (rec_count),
        .done      (done),
        .fsm_state (fsm_state)
`ifdef ALU_TV_CHECK_EN
        ,
        .err       (err)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [32:0] exp_q[$];
    int n_vec        = 0;
    int n_bad        = 0;
    int words_popped = 0;
    tv_rec_t vec [10];
    tv_rec_t bad_rec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented word must match the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL word_unexpected: got last=%b data=%h with no word expected",
                         bus.out_last, bus.out_data);
            end else begin
                if ({bus.out_last, bus.out_data} !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL word: got last=%b data=%h expected last=%b data=%h",
                             bus.out_last, bus.out_data, exp_q[0][32], exp_q[0][31:0]);
                end
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    words_popped++;
                end
            end
        end
    end

    // Driver tasks
    task automatic push_record(input tv_rec_t r);
        exp_q.push_back({1'b0, 29'b0, r.f});
        exp_q.push_back({1'b0, r.a});
        exp_q.push_back({1'b0, r.b});
        exp_q.push_back({1'b0, r.y});
        exp_q.push_back({1'b1, 31'b0, r.zero});
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic capture(input tv_rec_t r);
        bus.cap_valid = 1'b1;
        bus.cap_f     = r.f;
        bus.cap_a     = r.a;
        bus.cap_b     = r.b;
        bus.cap_y     = r.y;
        bus.cap_zero  = r.zero;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (bus.cap_ready) begin
                push_record(r);
                @(posedge clk); #1;
                bus.cap_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.cap_valid = 1'b0;
        n_vec++;
        n_bad++;
        $display("FAIL capture_timeout: cap_ready stayed 0, expected 1 within 200 cycles");
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 400 && !idle; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 && !bus.out_valid) idle = 1'b1;
        end
        n_vec++;
        if (!idle) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d words still pending, expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    int base;
    bit seen;
    bit stop;
    int pat [8];

    initial begin
        vec[0] = '{f: 3'd2, a: 32'd5,          b: 32'd7,          y: 32'd12,         zero: 1'b0};
        vec[1] = '{f: 3'd0, a: 32'hF0F0_F0F0, b: 32'h0FF0_0FF0, y: 32'h00F0_00F0, zero: 1'b0};
        vec[2] = '{f: 3'd1, a: 32'h1234_0000, b: 32'h0000_5678, y: 32'h1234_5678, zero: 1'b0};
        vec[3] = '{f: 3'd6, a: 32'd10,         b: 32'd10,         y: 32'd0,          zero: 1'b1};
        vec[4] = '{f: 3'd7, a: 32'hFFFF_FFFF, b: 32'd1,          y: 32'd1,          zero: 1'b0};
        vec[5] = '{f: 3'd4, a: 32'hFF00_FF00, b: 32'h0F0F_0F0F, y: 32'hF000_F000, zero: 1'b0};
        vec[6] = '{f: 3'd5, a: 32'h0000_0000, b: 32'hFFFF_0000, y: 32'h0000_FFFF, zero: 1'b0};
        vec[7] = '{f: 3'd6, a: 32'd3,          b: 32'd5,          y: 32'hFFFF_FFFE, zero: 1'b0};
        vec[8] = '{f: 3'd2, a: 32'hFFFF_FFFF, b: 32'd1,          y: 32'd0,          zero: 1'b1};
        vec[9] = '{f: 3'd7, a: 32'd5,          b: 32'd3,          y: 32'd0,          zero: 1'b1};
        bad_rec = '{f: 3'd6, a: 32'd3, b: 32'd3, y: 32'd1, zero: 1'b0};
        pat = '{1, 0, 0, 1, 0, 1, 1, 1};

        rst_n         = 1'b0;
        bus.cap_valid = 1'b0;
        bus.cap_f     = 3'd0;
        bus.cap_a     = 32'd0;
        bus.cap_b     = 32'd0;
        bus.cap_y     = 32'd0;
        bus.cap_zero  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  bus.out_data,       32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_rec_count", 32'(rec_count),     32'd0);
        check("rst_done",      32'(done),          32'd0);
        check("rst_state",     32'(fsm_state),     32'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_cap_ready", 32'(bus.cap_ready), 32'd1);

        // Single record, latency and back-to-back words
        bus.out_ready = 1'b1;
        capture(vec[0]);
        @(negedge clk);
        check("latency_not_yet_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < WORDS_PER_RECORD; i++) begin
            @(negedge clk);
            check("single_consecutive_valid", 32'(bus.out_valid), 32'd1);
        end
        @(negedge clk);
        check("single_valid_drops", 32'(bus.out_valid), 32'd0);
        check("single_rec_count",   32'(rec_count),     32'd1);
        @(posedge clk); #1;

        // Remaining ALU patterns streamed back to back
        for (int i = 1; i < 8; i++) capture(vec[i]);
        wait_idle();
        check("stream_rec_count", 32'(rec_count), 32'd8);

        // Backpressure: ready pattern 1,0,0,1,... within one record
        bus.out_ready = 1'b0;
        capture(vec[8]);
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            bus.out_ready = pat[k][0];
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        wait_idle();
        check("bp_rec_count", 32'(rec_count), 32'd9);

        // Full FIFO: four captures fill it, the fifth waits for the first pop
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) capture(vec[i]);
        @(negedge clk); #1;
        check("full_cap_ready", 32'(bus.cap_ready), 32'd0);
        @(posedge clk); #1;
        base = words_popped;
        fork
            begin
                capture(vec[4]);
                // counted words include the handshake in the accepting cycle
                check("fifth_accept_words_popped", 32'(words_popped - base), 32'd6);
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        wait_idle();
        check("full_rec_count", 32'(rec_count), 32'd14);

`ifdef ALU_TV_CHECK_EN
        // Model check: wrong y/zero raises err, record still emitted as given
        check("err_clear", 32'(err), 32'd0);
        capture(bad_rec);
        wait_idle();
        check("err_set", 32'(err), 32'd1);
        check("err_rec_count", 32'(rec_count), 32'd15);
`endif

        // Reset after the b word of a record
        bus.out_ready = 1'b0;
        capture(vec[1]);
        @(posedge clk); #1;
        base = words_popped;
        bus.out_ready = 1'b1;
        stop = 1'b0;
        for (int i = 0; i < 20 && !stop; i++) begin
            @(posedge clk); #1;
            if (words_popped - base >= 3) stop = 1'b1;
        end
        bus.out_ready = 1'b0;
        @(negedge clk); #1;
        check("midrec_state_before_reset", 32'(fsm_state), 32'(W_Y));
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_data",  bus.out_data,       32'd0);
        check("midrst_out_last",  32'(bus.out_last),  32'd0);
        check("midrst_rec_count", 32'(rec_count),     32'd0);
        check("midrst_done",      32'(done),          32'd0);
        check("midrst_state",     32'(fsm_state),     32'(IDLE));
`ifdef ALU_TV_CHECK_EN
        check("midrst_err", 32'(err), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_cap_ready", 32'(bus.cap_ready), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("midrst_no_replay", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        capture(vec[2]);
        wait_idle();
        check("post_rst_rec_count", 32'(rec_count), 32'd1);

        // Record limit: 20 more captures reach MAX_RECORDS since reset
        for (int i = 0; i < MAX_RECORDS - 1; i++) capture(vec[i % 10]);
        @(negedge clk); #1;
        check("limit_stop_pending_ready", 32'(bus.cap_ready), 32'd0);
        check("limit_done_not_yet",       32'(done),          32'd0);
        @(posedge clk); #1;
        bus.cap_valid = 1'b1;
        bus.cap_f     = vec[0].f;
        bus.cap_a     = vec[0].a;
        bus.cap_b     = vec[0].b;
        bus.cap_y     = vec[0].y;
        bus.cap_zero  = vec[0].zero;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (bus.cap_ready) seen = 1'b1;
        end
        check("limit_extra_refused", 32'(seen), 32'd0);
        stop = 1'b0;
        for (int i = 0; i < 200 && !stop; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) stop = 1'b1;
        end
        check("limit_drained",        32'(exp_q.size()), 32'd0);
        check("limit_done_before_last", 32'(done),       32'd0);
        check("limit_count_before_last", 32'(rec_count), 32'(MAX_RECORDS - 1));
        @(posedge clk); #1;
        check("limit_done_set",   32'(done),      32'd1);
        check("limit_rec_count",  32'(rec_count), 32'(MAX_RECORDS));
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (bus.cap_ready) seen = 1'b1;
        end
        bus.cap_valid = 1'b0;
        check("done_cap_ready_stays_0", 32'(seen),          32'd0);
        check("done_out_valid",         32'(bus.out_valid), 32'd0);
        check("done_sticky",            32'(done),          32'd1);

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
